// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the dsp48a1 arithmetic slice: OPMODE field
// positions and the X/Z post-adder operand select encodings.
package dsp48a1_pkg;

  // OPMODE bit positions (applied to the OPMODE stage output)
  localparam int OPM_X_LSB    = 0;  // [1:0] X mux select
  localparam int OPM_Z_LSB    = 2;  // [3:2] Z mux select
  localparam int OPM_B1_SEL   = 4;  // 1: B1 takes the pre-adder result
  localparam int OPM_CIN      = 5;  // carry-in when CARRYINSEL = "OPMODE5"
  localparam int OPM_PRE_SUB  = 6;  // 1: pre-adder computes D - B0
  localparam int OPM_POST_SUB = 7;  // 1: post-adder computes Z - (X + CIN)

  // X operand select
  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  // Z operand select
  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp48a1_dsp_reg_mux.sv
// Optional pipeline stage: a CE-gated register with asynchronous
// active-low clear, or a plain wire when REGISTERED is 0.
module dsp_reg_mux #(
  parameter int WIDTH      = 18,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_q;

      // Stage register: reset clears regardless of CE, otherwise load on CE
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q <= {WIDTH{1'b0}};
        end else if (i_ce) begin
          r_q <= i_d;
        end else begin
          r_q <= r_q;
        end
      end

      assign o_q = r_q;
    end else begin : g_bypass
      // Clock, reset and CE have no effect on a bypassed stage
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst_n, i_ce};
      assign o_q      = i_d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1.sv
// DSP48A1-style slice: 18-bit pre-adder, 18x18 unsigned multiplier and
// 48-bit post-adder/accumulator with carry. Each pipeline stage is an
// optional register selected by its parameter.
module dsp48a1
  import dsp48a1_pkg::*;
#(
  parameter int    WIDTH_1     = 8,
  parameter int    WIDTH_2     = 18,
  parameter int    WIDTH_3     = 36,
  parameter int    WIDTH_4     = 48,
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic               CLK,
  input  logic               RSTA,
  input  logic               RSTB,
  input  logic               RSTC,
  input  logic               RSTD,
  input  logic               RSTM,
  input  logic               RSTP,
  input  logic               RSTCARRYIN,
  input  logic               RSTOPMODE,
  input  logic               CEA,
  input  logic               CEB,
  input  logic               CEC,
  input  logic               CED,
  input  logic               CEM,
  input  logic               CEP,
  input  logic               CECARRYIN,
  input  logic               CEOPMODE,
  input  logic [WIDTH_2-1:0] A,
  input  logic [WIDTH_2-1:0] B,
  input  logic [WIDTH_2-1:0] D,
  input  logic [WIDTH_2-1:0] BCIN,
  input  logic [WIDTH_4-1:0] C,
  input  logic [WIDTH_4-1:0] PCIN,
  input  logic [WIDTH_1-1:0] OPMODE,
  input  logic               CARRYIN,
  output logic [WIDTH_2-1:0] BCOUT,
  output logic [WIDTH_3-1:0] M,
  output logic [WIDTH_4-1:0] P,
  output logic [WIDTH_4-1:0] PCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF
);

  // Anything other than the exact alternate string falls back to the default
  localparam bit USE_CARRYIN_PORT = (CARRYINSEL == "CARRYIN");
  localparam bit USE_BCIN         = (B_INPUT == "CASCADE");

  logic [WIDTH_1-1:0] w_opmode;
  logic [WIDTH_2-1:0] w_a0;
  logic [WIDTH_2-1:0] w_a1;
  logic [WIDTH_2-1:0] w_b_src;
  logic [WIDTH_2-1:0] w_b0;
  logic [WIDTH_2-1:0] w_preadd;
  logic [WIDTH_2-1:0] w_b1_in;
  logic [WIDTH_2-1:0] w_b1;
  logic [WIDTH_2-1:0] w_d;
  logic [WIDTH_4-1:0] w_c;
  logic [WIDTH_3-1:0] w_mult;
  logic [WIDTH_3-1:0] w_m;
  logic [WIDTH_4-1:0] w_x;
  logic [WIDTH_4-1:0] w_z;
  logic               w_cin_src;
  logic               w_cin;
  logic [WIDTH_4:0]   w_post;
  logic [WIDTH_4-1:0] w_p;
  logic               w_co;

  // ---------------------------------------------------------------
  // Input stages
  // ---------------------------------------------------------------
  dsp_reg_mux #(.WIDTH(WIDTH_1), .REGISTERED(OPMODEREG != 0)) u_opmode_reg (
    .i_clk(CLK), .i_rst_n(RSTOPMODE), .i_ce(CEOPMODE), .i_d(OPMODE), .o_q(w_opmode)
  );

  dsp_reg_mux #(.WIDTH(WIDTH_2), .REGISTERED(A0REG != 0)) u_a0_reg (
    .i_clk(CLK), .i_rst_n(RSTA), .i_ce(CEA), .i_d(A), .o_q(w_a0)
  );

  dsp_reg_mux #(.WIDTH(WIDTH_2), .REGISTERED(A1REG != 0)) u_a1_reg (
    .i_clk(CLK), .i_rst_n(RSTA), .i_ce(CEA), .i_d(w_a0), .o_q(w_a1)
  );

  assign w_b_src = USE_BCIN ? BCIN : B;

  dsp_reg_mux #(.WIDTH(WIDTH_2), .REGISTERED(B0REG != 0)) u_b0_reg (
    .i_clk(CLK), .i_rst_n(RSTB), .i_ce(CEB), .i_d(w_b_src), .o_q(w_b0)
  );

  dsp_reg_mux #(.WIDTH(WIDTH_2), .REGISTERED(DREG != 0)) u_d_reg (
    .i_clk(CLK), .i_rst_n(RSTD), .i_ce(CED), .i_d(D), .o_q(w_d)
  );

  dsp_reg_mux #(.WIDTH(WIDTH_4), .REGISTERED(CREG != 0)) u_c_reg (
    .i_clk(CLK), .i_rst_n(RSTC), .i_ce(CEC), .i_d(C), .o_q(w_c)
  );

  // ---------------------------------------------------------------
  // Pre-adder and B1 stage
  // ---------------------------------------------------------------

  // Pre-adder: D +/- B0, wrapping at the operand width
  always_comb begin
    if (w_opmode[OPM_PRE_SUB]) begin
      w_preadd = w_d - w_b0;
    end else begin
      w_preadd = w_d + w_b0;
    end
  end

  // B1 source: pre-adder result or the raw B0 operand
  always_comb begin
    if (w_opmode[OPM_B1_SEL]) begin
      w_b1_in = w_preadd;
    end else begin
      w_b1_in = w_b0;
    end
  end

  dsp_reg_mux #(.WIDTH(WIDTH_2), .REGISTERED(B1REG != 0)) u_b1_reg (
    .i_clk(CLK), .i_rst_n(RSTB), .i_ce(CEB), .i_d(w_b1_in), .o_q(w_b1)
  );

  // ---------------------------------------------------------------
  // Multiplier stage
  // ---------------------------------------------------------------
  assign w_mult = {{(WIDTH_3-WIDTH_2){1'b0}}, w_a1} * {{(WIDTH_3-WIDTH_2){1'b0}}, w_b1};

  dsp_reg_mux #(.WIDTH(WIDTH_3), .REGISTERED(MREG != 0)) u_m_reg (
    .i_clk(CLK), .i_rst_n(RSTM), .i_ce(CEM), .i_d(w_mult), .o_q(w_m)
  );

  // ---------------------------------------------------------------
  // Post-adder operand muxes and carry-in
  // ---------------------------------------------------------------

  // X operand: zero, zero-extended M, P feedback, or the D:A:B concatenation
  always_comb begin
    w_x = {WIDTH_4{1'b0}};
    case (x_sel_e'(w_opmode[OPM_X_LSB +: 2]))
      X_ZERO:  w_x = {WIDTH_4{1'b0}};
      X_M:     w_x = {{(WIDTH_4-WIDTH_3){1'b0}}, w_m};
      X_P:     w_x = w_p;
      X_DAB:   w_x = {w_d[WIDTH_4-2*WIDTH_2-1:0], w_a1, w_b1};
      default: w_x = {WIDTH_4{1'b0}};
    endcase
  end

  // Z operand: zero, cascade input, P feedback, or the registered C operand
  always_comb begin
    w_z = {WIDTH_4{1'b0}};
    case (z_sel_e'(w_opmode[OPM_Z_LSB +: 2]))
      Z_ZERO:  w_z = {WIDTH_4{1'b0}};
      Z_PCIN:  w_z = PCIN;
      Z_P:     w_z = w_p;
      Z_C:     w_z = w_c;
      default: w_z = {WIDTH_4{1'b0}};
    endcase
  end

  assign w_cin_src = USE_CARRYIN_PORT ? CARRYIN : w_opmode[OPM_CIN];

  dsp_reg_mux #(.WIDTH(1), .REGISTERED(CARRYINREG != 0)) u_cyi_reg (
    .i_clk(CLK), .i_rst_n(RSTCARRYIN), .i_ce(CECARRYIN), .i_d(w_cin_src), .o_q(w_cin)
  );

  // ---------------------------------------------------------------
  // Post-adder and output stages
  // ---------------------------------------------------------------

  // Post-adder: one extra bit carries the carry/borrow out of the 48-bit result
  always_comb begin
    if (w_opmode[OPM_POST_SUB]) begin
      w_post = {1'b0, w_z} - ({1'b0, w_x} + {{WIDTH_4{1'b0}}, w_cin});
    end else begin
      w_post = {1'b0, w_z} + {1'b0, w_x} + {{WIDTH_4{1'b0}}, w_cin};
    end
  end

  dsp_reg_mux #(.WIDTH(WIDTH_4), .REGISTERED(PREG != 0)) u_p_reg (
    .i_clk(CLK), .i_rst_n(RSTP), .i_ce(CEP), .i_d(w_post[WIDTH_4-1:0]), .o_q(w_p)
  );

  dsp_reg_mux #(.WIDTH(1), .REGISTERED(CARRYOUTREG != 0)) u_co_reg (
    .i_clk(CLK), .i_rst_n(RSTCARRYIN), .i_ce(CECARRYIN), .i_d(w_post[WIDTH_4]), .o_q(w_co)
  );

  assign BCOUT     = w_b1;
  assign M         = w_m;
  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_co;
  assign CARRYOUTF = w_co;

endmodule

// File: tb/tb_dsp48a1.sv
// Directed bench for dsp48a1 with default parameters: expected results are
// queued when stimulus is applied and compared once the pipeline has settled;
// latency, clock-enable and reset behaviour are checked cycle by cycle.
module tb_dsp48a1;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  typedef struct {
    string       tag;
    logic [17:0] bc;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  dsp48a1 dut (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTD = v;
    RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
  endtask

  task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic [47:0] c, input logic [47:0] pcin,
                       input logic [7:0] opm, input logic cin);
    A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = opm; CARRYIN = cin;
  endtask

  // Pop the oldest expectation and compare every result port against it
  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1 pending entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_bcout"}, 64'(BCOUT), 64'(e.bc));
      chk({e.tag, "_m"}, 64'(M), 64'(e.m));
      chk({e.tag, "_p"}, 64'(P), 64'(e.p));
      chk({e.tag, "_pcout"}, 64'(PCOUT), 64'(e.p));
      chk({e.tag, "_co"}, 64'(CARRYOUT), 64'(e.co));
      chk({e.tag, "_cof"}, 64'(CARRYOUTF), 64'(e.co));
    end
  endtask

  // Steady-state reference for non-feedback OPMODEs with CARRYINSEL = OPMODE5
  function automatic exp_t model(input string tag, input logic [17:0] a, input logic [17:0] b,
                                 input logic [17:0] d, input logic [47:0] c,
                                 input logic [47:0] pcin, input logic [7:0] opm);
    exp_t        e;
    logic [17:0] pre, b1;
    logic [35:0] m;
    logic [47:0] x, z;
    logic [48:0] r;
    pre = opm[6] ? (d - b) : (d + b);
    b1  = opm[4] ? pre : b;
    m   = {18'd0, a} * {18'd0, b1};
    case (opm[1:0])
      2'd1:    x = {12'd0, m};
      2'd3:    x = {d[11:0], a, b1};
      default: x = 48'd0;
    endcase
    case (opm[3:2])
      2'd1:    z = pcin;
      2'd3:    z = c;
      default: z = 48'd0;
    endcase
    if (opm[7]) r = {1'b0, z} - ({1'b0, x} + {48'd0, opm[5]});
    else        r = {1'b0, z} + {1'b0, x} + {48'd0, opm[5]};
    e.tag = tag; e.bc = b1; e.m = m; e.p = r[47:0]; e.co = r[48];
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [17:0] ra, rb, rd;
    logic [47:0] rc, rpcin;
    logic [7:0]  ropm;

    set_rst(1'b0);
    CEA = 1'b1; CEB = 1'b1; CEC = 1'b1; CED = 1'b1;
    CEM = 1'b1; CEP = 1'b1; CECARRYIN = 1'b1; CEOPMODE = 1'b1;
    BCIN = 18'h3FFFF;
    drive(18'd7, 18'd7, 18'd7, 48'd7, 48'd7, 8'b0001_1101, 1'b1);
    step(2);
    chk("reset_p", 64'(P), 64'd0);
    chk("reset_pcout", 64'(PCOUT), 64'd0);
    chk("reset_m", 64'(M), 64'd0);
    chk("reset_bcout", 64'(BCOUT), 64'd0);
    chk("reset_co", 64'(CARRYOUT), 64'd0);
    chk("reset_cof", 64'(CARRYOUTF), 64'd0);
    set_rst(1'b1);

    // Directed patterns, each held long enough to fill the pipeline
    drive(18'd2, 18'd3, 18'd5, 48'd0, 48'd0, 8'b0001_0001, 1'b0);
    sb_q.push_back('{"preadd_mul", 18'd8, 36'd16, 48'd16, 1'b0});
    step(5); sb_check();

    drive(18'd2, 18'd3, 18'd5, 48'd0, 48'd0, 8'b0101_0001, 1'b0);
    sb_q.push_back('{"presub_mul", 18'd2, 36'd4, 48'd4, 1'b0});
    step(5); sb_check();

    drive(18'd2, 18'd3, 18'd5, 48'd100, 48'd0, 8'b1001_1101, 1'b0);
    sb_q.push_back('{"post_sub", 18'd8, 36'd16, 48'd84, 1'b0});
    step(5); sb_check();

    drive(18'd1, 18'd2, 18'd3, 48'd0, 48'd0, 8'b0000_0011, 1'b0);
    sb_q.push_back('{"concat", 18'd2, 36'd2, 48'h0030_0004_0002, 1'b0});
    step(5); sb_check();

    drive(18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 8'b0000_1101, 1'b0);
    sb_q.push_back('{"carry", 18'd1, 36'd1, 48'd0, 1'b1});
    step(5); sb_check();

    drive(18'd1, 18'd1, 18'd0, 48'd5, 48'd0, 8'b0010_1100, 1'b0);
    sb_q.push_back('{"cin_opmode5", 18'd1, 36'd1, 48'd6, 1'b0});
    step(5); sb_check();

    drive(18'd2, 18'd3, 18'd0, 48'd100, 48'd0, 8'b1010_1101, 1'b0);
    sb_q.push_back('{"sub_cin", 18'd3, 36'd6, 48'd93, 1'b0});
    step(5); sb_check();

    drive(18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 8'b1000_1101, 1'b0);
    sb_q.push_back('{"sub_borrow", 18'd1, 36'd1, 48'hFFFF_FFFF_FFFF, 1'b1});
    step(5); sb_check();

    drive(18'd3, 18'd4, 18'd0, 48'd0, 48'd1000, 8'b0000_0101, 1'b0);
    sb_q.push_back('{"pcin", 18'd4, 36'd12, 48'd1012, 1'b0});
    step(5); sb_check();

    drive(18'd1, 18'd1, 18'd0, 48'd5, 48'd0, 8'b0000_1100, 1'b1);
    sb_q.push_back('{"carryin_port_ignored", 18'd1, 36'd1, 48'd5, 1'b0});
    step(5); sb_check();

    // Random non-feedback patterns against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
      rc = 48'({$urandom, $urandom}); rpcin = 48'({$urandom, $urandom});
      ropm = 8'($urandom);
      if (ropm[1:0] == 2'd2) ropm[1:0] = 2'd3;
      if (ropm[3:2] == 2'd2) ropm[3:2] = 2'd1;
      drive(ra, rb, rd, rc, rpcin, ropm, 1'b0);
      sb_q.push_back(model($sformatf("rand%0d", i), ra, rb, rd, rc, rpcin, ropm));
      step(5); sb_check();
    end

    // C path: two cycles to P
    drive(18'd0, 18'd0, 18'd0, 48'd10, 48'd0, 8'b0000_1100, 1'b0);
    step(5);
    C = 48'd20;
    step(1); chk("lat_c_1", 64'(P), 64'd10);
    step(1); chk("lat_c_2", 64'(P), 64'd20);

    // A path: A1 then M then P
    drive(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 8'b0000_0001, 1'b0);
    step(5);
    A = 18'd5;
    step(1); chk("lat_a_m1", 64'(M), 64'd6);
    step(1); chk("lat_a_m2", 64'(M), 64'd15); chk("lat_a_p2", 64'(P), 64'd6);
    step(1); chk("lat_a_p3", 64'(P), 64'd15);

    // B path: BCOUT one cycle behind B, M one behind BCOUT
    B = 18'd4;
    step(1); chk("lat_b_bcout1", 64'(BCOUT), 64'd4); chk("lat_b_m1", 64'(M), 64'd15);
    step(1); chk("lat_b_m2", 64'(M), 64'd20);

    // D through pre-adder: four cycles to P
    drive(18'd1, 18'd0, 18'd5, 48'd0, 48'd0, 8'b0001_0001, 1'b0);
    step(6);
    D = 18'd9;
    step(1); chk("lat_d_bcout1", 64'(BCOUT), 64'd5);
    step(1); chk("lat_d_bcout2", 64'(BCOUT), 64'd9);
    step(1); chk("lat_d_m3", 64'(M), 64'd9); chk("lat_d_p3", 64'(P), 64'd5);
    step(1); chk("lat_d_p4", 64'(P), 64'd9);

    // OPMODE: two cycles to P
    OPMODE = 8'b0001_0000;
    step(1); chk("lat_opm_1", 64'(P), 64'd9);
    step(1); chk("lat_opm_2", 64'(P), 64'd0);

    // CEM low holds M
    CEM = 1'b0; A = 18'd3;
    step(3); chk("cem_hold", 64'(M), 64'd9);
    CEM = 1'b1;
    step(2); chk("cem_resume", 64'(M), 64'd27);

    // Accumulate P + M every enabled cycle, starting from a cleared P
    drive(18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 8'b0000_1001, 1'b0);
    RSTP = 1'b0;
    step(4); chk("acc_rst_over_ce", 64'(P), 64'd0);
    RSTP = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1); chk($sformatf("acc_%0d", k), 64'(P), 64'(k));
    end
    CEP = 1'b0;
    step(3); chk("acc_cep_freeze", 64'(P), 64'd4);
    CEP = 1'b1;
    step(1); chk("acc_cep_resume", 64'(P), 64'd5);

    // Mid-operation asynchronous reset, away from the clock edge
    step(1);
    @(posedge CLK); #3;
    set_rst(1'b0);
    #1;
    chk("async_rst_p", 64'(P), 64'd0);
    chk("async_rst_m", 64'(M), 64'd0);
    chk("async_rst_bcout", 64'(BCOUT), 64'd0);
    chk("async_rst_co", 64'(CARRYOUT), 64'd0);
    step(1); chk("rst_hold_p", 64'(P), 64'd0); chk("rst_hold_m", 64'(M), 64'd0);
    set_rst(1'b1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
